// File: rtl/mux_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_arbiter_pkg                                                   |
// | Shared types and helpers for the round-robin burst arbiter.       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package mux_arbiter_pkg;

  // Arbiter FSM: free (IDLE) or holding the selector key (LOCK).
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Total width of a packed bus carrying one slice per requester.
  function automatic int bus_width(input int nr, input int len);
    return nr * len;
  endfunction

  // Add two indices modulo n. Operands are already below n, so a single
  // conditional subtract is enough.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_arbiter_if                                                    |
// | Requester and sink handshake bundle for mux_arbiter.              |
// | master: requesters plus sink (environment); slave: the arbiter.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface mux_arbiter_if #(
  parameter int NR_REQ   = 4,
  parameter int IDX_LEN  = 2,
  parameter int DATA_LEN = 8
);
  import mux_arbiter_pkg::*;

  logic [NR_REQ-1:0]                          req_valid;
  logic [bus_width(NR_REQ, DATA_LEN)-1:0]     req_data;
  logic [NR_REQ-1:0]                          req_last;
  logic [NR_REQ-1:0]                          req_ready;
  logic                                       out_valid;
  logic [DATA_LEN-1:0]                        out_data;
  logic                                       out_last;
  logic                                       out_ready;
  logic [IDX_LEN-1:0]                         grant_idx;
  logic                                       busy;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, grant_idx, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, grant_idx, busy
  );

endinterface
`default_nettype wire

// File: rtl/mux_arbiter_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick                                                           |
// | Combinational round-robin winner search: first valid requester    |
// | at or above prev_idx+1, wrapping modulo NR_REQ.                   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module rr_pick #(
  parameter int NR_REQ  = 4,
  parameter int IDX_LEN = 2
) (
  input  logic [NR_REQ-1:0]  req_valid,
  input  logic [IDX_LEN-1:0] prev_idx,
  output logic [IDX_LEN-1:0] winner,
  output logic               any
);
  import mux_arbiter_pkg::*;

  logic [IDX_LEN-1:0] start;
  logic [NR_REQ-1:0]  rot;
  logic [IDX_LEN-1:0] enc;

  // Rotate so the search start lands on bit 0, priority-encode, rotate back.
  always_comb begin
    start = IDX_LEN'(wrap_add(int'(prev_idx), 1, NR_REQ));
    rot   = NR_REQ'({req_valid, req_valid} >> start);
    enc   = '0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc = IDX_LEN'(i);
      end
    end
    winner = IDX_LEN'(wrap_add(int'(enc), int'(start), NR_REQ));
    any    = |req_valid;
  end

endmodule
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_arbiter                                                       |
// | Round-robin burst arbiter: grants one requester the output        |
// | selector for a whole burst (ended by last or a beat limit) and    |
// | forwards its stream combinationally to the shared sink.           |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mux_arbiter #(
  parameter int NR_REQ    = 4,
  parameter int IDX_LEN   = 2,
  parameter int DATA_LEN  = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_LEN   = 5
) (
  input logic          clk,
  input logic          rst_n,
  mux_arbiter_if.slave bus
);
  import mux_arbiter_pkg::*;

  localparam logic [CNT_LEN-1:0] CNT_SAT    = '1;
  localparam logic [CNT_LEN-1:0] LIMIT_LAST =
    CNT_LEN'((MAX_BEATS == 0) ? 0 : (MAX_BEATS - 1));
  localparam logic [IDX_LEN-1:0] PREV_RST   = IDX_LEN'(NR_REQ - 1);

  arb_state_t         state, state_nx;
  logic [IDX_LEN-1:0] grant, grant_nx;
  logic [IDX_LEN-1:0] prev_idx, prev_nx;
  logic [CNT_LEN-1:0] beat_cnt, cnt_nx;

  logic [IDX_LEN-1:0] pick_idx;
  logic               pick_any;

  logic               sel_valid;
  logic               sel_last;
  logic [DATA_LEN-1:0] sel_data;
  logic               limit_hit;

  logic               out_valid_w;
  logic [DATA_LEN-1:0] out_data_w;
  logic               out_last_w;
  logic [NR_REQ-1:0]  req_ready_w;

  rr_pick #(
    .NR_REQ  (NR_REQ),
    .IDX_LEN (IDX_LEN)
  ) u_pick (
    .req_valid (bus.req_valid),
    .prev_idx  (prev_idx),
    .winner    (pick_idx),
    .any       (pick_any)
  );

  // Keyed mux on the grant index; an out-of-range key yields zeros.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int n = 0; n < NR_REQ; n++) begin
      if (grant == IDX_LEN'(n)) begin
        sel_valid = bus.req_valid[n];
        sel_last  = bus.req_last[n];
        sel_data  = bus.req_data[n*DATA_LEN +: DATA_LEN];
      end
    end
  end

  // Forced end of burst once the owner has had MAX_BEATS-1 beats accepted.
  always_comb begin
    limit_hit = (MAX_BEATS != 0) && (beat_cnt == LIMIT_LAST);
  end

  // Next-state and forwarding logic; everything is quiet outside LOCK.
  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    prev_nx     = prev_idx;
    cnt_nx      = beat_cnt;
    out_valid_w = 1'b0;
    out_data_w  = '0;
    out_last_w  = 1'b0;
    req_ready_w = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nx = pick_idx;
          cnt_nx   = '0;
          state_nx = LOCK;
        end
      end
      LOCK: begin
        out_valid_w = sel_valid;
        out_data_w  = sel_data;
        out_last_w  = sel_last | limit_hit;
        for (int n = 0; n < NR_REQ; n++) begin
          req_ready_w[n] = (grant == IDX_LEN'(n)) && bus.out_ready;
        end
        if (sel_valid && bus.out_ready) begin
          // Saturate rather than wrap; only reachable with the limit off.
          if (beat_cnt != CNT_SAT) begin
            cnt_nx = beat_cnt + CNT_LEN'(1);
          end
          if (out_last_w) begin
            prev_nx  = grant;
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, owner, round-robin pointer and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      prev_idx <= PREV_RST;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      prev_idx <= prev_nx;
      beat_cnt <= cnt_nx;
    end
  end

  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_data_w;
  assign bus.out_last  = out_last_w;
  assign bus.req_ready = req_ready_w;
  assign bus.grant_idx = grant;
  assign bus.busy      = (state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mux_arbiter                                                    |
// | Self-checking bench: behavioural arbiter model, per-cycle compare |
// | and directed plus randomized requester traffic.                   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_mux_arbiter;

  localparam int N    = 4;
  localparam int IL   = 2;
  localparam int DL   = 8;
  localparam int MAXB = 4;
  localparam int CL   = 5;
  localparam int QD   = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_arbiter_if #(.NR_REQ(N), .IDX_LEN(IL), .DATA_LEN(DL)) bus ();

  mux_arbiter #(
    .NR_REQ(N), .IDX_LEN(IL), .DATA_LEN(DL), .MAX_BEATS(MAXB), .CNT_LEN(CL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Requester beat queues: {last, data}, ring buffers indexed by head/tail.
  logic [DL:0] fifo [N][QD];
  int          head [N];
  int          tail [N];
  bit          en   [N];

  // Behavioural model of the arbiter.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_prev  = N - 1;
  int m_cnt   = 0;
  bit m_acc   = 1'b0;
  int m_acc_n = 0;
  bit m_found;
  int m_c;
  bit m_last;

  // Model update: search upward from prev+1 in IDLE; count beats and release in LOCK.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_prev = N - 1; m_cnt = 0; m_acc = 1'b0;
    end else begin
      m_acc = 1'b0;
      if (!m_busy) begin
        m_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          m_c = (m_prev + k) % N;
          if (!m_found && bus.req_valid[m_c]) begin
            m_found = 1'b1; m_owner = m_c; m_busy = 1'b1; m_cnt = 0;
          end
        end
      end else if (bus.req_valid[m_owner] && bus.out_ready) begin
        m_acc   = 1'b1;
        m_acc_n = m_owner;
        m_last  = bus.req_last[m_owner] || (m_cnt == MAXB - 1);
        m_cnt   = m_cnt + 1;
        if (m_last) begin
          m_prev = m_owner; m_busy = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model, away from the edge.
  bit          chk_en    = 1'b0;
  logic        obs_valid;
  logic [DL-1:0] obs_data;
  logic        obs_last;
  logic [N-1:0] obs_ready;
  logic        e_valid, e_last;
  logic [DL-1:0] e_data;
  logic [N-1:0] e_ready;

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      e_valid = 1'b0; e_data = '0; e_last = 1'b0; e_ready = '0;
      if (m_busy) begin
        e_valid = bus.req_valid[m_owner];
        e_data  = bus.req_data[m_owner*DL +: DL];
        e_last  = bus.req_last[m_owner] || (m_cnt == MAXB - 1);
        e_ready = bus.out_ready ? N'(1 << m_owner) : '0;
      end
      check("busy",      32'(bus.busy),      32'(m_busy));
      check("grant_idx", 32'(bus.grant_idx), 32'(m_owner));
      check("out_valid", 32'(bus.out_valid), 32'(e_valid));
      check("out_data",  32'(bus.out_data),  32'(e_data));
      check("out_last",  32'(bus.out_last),  32'(e_last));
      check("req_ready", 32'(bus.req_ready), 32'(e_ready));
      obs_valid = bus.out_valid;
      obs_data  = bus.out_data;
      obs_last  = bus.out_last;
      obs_ready = bus.req_ready;
    end
  end

  task automatic push(input int n, input logic [DL-1:0] d, input logic l);
    fifo[n][tail[n] % QD] = {l, d};
    tail[n]++;
  endtask

  task automatic drive(input bit rdy);
    logic [N-1:0]    v, l;
    logic [N*DL-1:0] d;
    v = '0; l = '0; d = '0;
    for (int n = 0; n < N; n++) begin
      if (tail[n] != head[n]) begin
        v[n]           = en[n];
        l[n]           = fifo[n][head[n] % QD][DL];
        d[n*DL +: DL]  = fifo[n][head[n] % QD][DL-1:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.out_ready = rdy;
  endtask

  // One clock: apply inputs, let the edge happen, retire the accepted beat.
  task automatic step(input bit rdy);
    drive(rdy);
    @(posedge clk);
    #1;
    if (m_acc) head[m_acc_n]++;
  endtask

  task automatic hard_reset();
    for (int n = 0; n < N; n++) begin head[n] = 0; tail[n] = 0; en[n] = 1'b1; end
    rst_n = 1'b0;
    drive(1'b1);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse in the middle of a cycle; outputs must clear at once.
  task automatic reset_pulse(input bit rdy);
    drive(rdy);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_grant",     32'(bus.grant_idx), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    if (m_acc) head[m_acc_n]++;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < N; n++) en[n] = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      done = !m_busy;
      for (int n = 0; n < N; n++) if (tail[n] != head[n]) done = 1'b0;
      if (!done) step(1'b1);
    end
    check("drain_complete", 32'(done), 32'd1);
  endtask

  int exp_rr [5] = '{0, 1, 2, 3, 0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    hard_reset();
    chk_en = 1'b1;

    // Reset state.
    drive(1'b1);
    #1;
    check("reset_busy",      32'(bus.busy),      32'd0);
    check("reset_grant",     32'(bus.grant_idx), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;

    // Single requester 2, three beats.
    push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    step(1'b1);
    check("single_grant", 32'(bus.grant_idx), 32'd2);
    check("single_busy",  32'(bus.busy),      32'd1);
    step(1'b1); check("single_beat1", 32'(obs_data), 32'hA1);
    step(1'b1); check("single_beat2", 32'(obs_data), 32'hA2);
    step(1'b1); check("single_beat3", 32'(obs_data), 32'hA3);
    check("single_last3", 32'(obs_last), 32'd1);
    check("single_idle",  32'(bus.busy), 32'd0);

    // All four requesting 1-beat bursts from reset: 0,1,2,3,0 with a bubble.
    hard_reset();
    push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b1); push(2, 8'h30, 1'b1); push(3, 8'h40, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      check("rr_grant", 32'(bus.grant_idx), 32'(exp_rr[i]));
      check("rr_busy",  32'(bus.busy),      32'd1);
      step(1'b1);
      check("rr_bubble", 32'(bus.busy), 32'd0);
    end

    // Backpressure mid-burst on requester 1.
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b0); push(1, 8'hB3, 1'b1);
    step(1'b1); check("bp_grant", 32'(bus.grant_idx), 32'd1);
    step(1'b1); check("bp_beat0", 32'(obs_data), 32'hB0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check("bp_ready_low", 32'(obs_ready), 32'd0);
      check("bp_hold_data", 32'(obs_data),  32'hB1);
    end
    step(1'b1); check("bp_beat1", 32'(obs_data), 32'hB1);
    step(1'b1); check("bp_beat2", 32'(obs_data), 32'hB2);
    step(1'b1); check("bp_beat3", 32'(obs_data), 32'hB3);
    check("bp_last", 32'(obs_last), 32'd1);

    // Beat limit: requester 1 never sets last, requester 3 waits.
    for (int j = 0; j < 6; j++) push(1, 8'hD0 + 8'(j), 1'b0);
    step(1'b1); check("lim_grant1", 32'(bus.grant_idx), 32'd1);
    push(3, 8'hE0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      step(1'b1);
      check("lim_data", 32'(obs_data), 32'hD0 + 32'(j));
      check("lim_last", 32'(obs_last), (j == 3) ? 32'd1 : 32'd0);
    end
    check("lim_release", 32'(bus.busy), 32'd0);
    step(1'b1); check("lim_grant3", 32'(bus.grant_idx), 32'd3);
    push(1, 8'hD6, 1'b1);
    drain();

    // Owner drops valid mid-burst while requester 1 waits.
    hard_reset();
    push(0, 8'hF0, 1'b0); push(0, 8'hF1, 1'b0); push(0, 8'hF2, 1'b1);
    push(1, 8'h60, 1'b1);
    step(1'b1); check("drop_grant0", 32'(bus.grant_idx), 32'd0);
    step(1'b1); check("drop_beat0", 32'(obs_data), 32'hF0);
    en[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1);
      check("drop_valid_low", 32'(obs_valid),     32'd0);
      check("drop_hold",      32'(bus.grant_idx), 32'd0);
    end
    en[0] = 1'b1;
    step(1'b1); check("drop_beat1", 32'(obs_data), 32'hF1);
    step(1'b1); check("drop_beat2", 32'(obs_data), 32'hF2);
    step(1'b1); check("drop_grant1", 32'(bus.grant_idx), 32'd1);
    drain();

    // Reset during beat 2 of requester 2; lowest valid index wins afterwards.
    push(2, 8'h70, 1'b0); push(2, 8'h71, 1'b0); push(2, 8'h72, 1'b1);
    step(1'b1); check("rstm_grant2", 32'(bus.grant_idx), 32'd2);
    push(0, 8'h80, 1'b1); push(3, 8'h90, 1'b1);
    step(1'b1); check("rstm_beat0", 32'(obs_data), 32'h70);
    reset_pulse(1'b1);
    check("rstm_regrant", 32'(bus.grant_idx), 32'd0);
    check("rstm_busy",    32'(bus.busy),      32'd1);
    drain();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < N; n++) begin
        en[n] = ($urandom_range(0, 3) != 0);
        if ((tail[n] - head[n]) < 3 && $urandom_range(0, 3) == 0)
          push(n, 8'($urandom), ($urandom_range(0, 2) == 0));
      end
      if ($urandom_range(0, 499) == 0) reset_pulse($urandom_range(0, 3) != 0);
      else step($urandom_range(0, 3) != 0);
    end
    for (int n = 0; n < N; n++) push(n, 8'hFF, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
